// File: rtl/mesh_link_pipe.sv
// mesh_link_pipe: pipelined, flow-controlled router-to-router NoC link.
// noc_pkg (first in this file) supplies VC_NUM and flit_t.
// Forward path: STAGES register stages feed per-VC skid FIFOs. A round-robin
// arbiter then picks among the VCs that hold a flit and that downstream has
// switched on.
// Backward path: on/off, re-derived from skid occupancy, plus allocatable,
// each delayed by STAGES register stages.
// Optional feature: define LINK_STATS_EN to add the flit_cnt_o/stall_cnt_o
// counters.
//
// Flow-control contract: the link has no ready signal. Upstream may assert
// is_valid_i for a flit of VC v only in a cycle where is_on_off_o[v] = 1, and
// the flit is then taken unconditionally. Downstream takes data_o in every
// cycle where is_valid_o = 1. Downstream allows that only for VCs it drives
// on through is_on_off_i.

package noc_pkg;
  localparam int VC_NUM = 4;
  localparam int VC_W   = 2;

  typedef struct packed {
    logic [VC_W-1:0] vc_id;
    logic [29:0]     payload;
  } flit_t;
endpackage

module mesh_link_pipe
  import noc_pkg::*;
#(
  parameter int STAGES     = 2,
  parameter int SKID_DEPTH = 2*STAGES+3,
  parameter int ON_THRESH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  flit_t             data_i,
  input  logic              is_valid_i,
  output logic [VC_NUM-1:0] is_on_off_o,
  output logic [VC_NUM-1:0] is_allocatable_o,
  output flit_t             data_o,
  output logic              is_valid_o,
  input  logic [VC_NUM-1:0] is_on_off_i,
  input  logic [VC_NUM-1:0] is_allocatable_i,
  output logic [VC_NUM-1:0] error_o
`ifdef LINK_STATS_EN
  ,
  output logic [31:0]       flit_cnt_o,
  output logic [31:0]       stall_cnt_o
`endif
);

  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int OCC_W = $clog2(SKID_DEPTH + 1);
  localparam int RR_W  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  logic                    last_valid;
  flit_t                   last_flit;
  logic [VC_NUM-1:0]       local_on;
  logic [VC_NUM-1:0]       nonempty;
  logic [VC_NUM-1:0]       eligible;
  flit_t [VC_NUM-1:0]      head;
  logic [RR_W-1:0]         rr_ptr;
  logic [RR_W-1:0]         grant_vc;
  logic                    grant_any;
  int                      cand;

  // Register stages: forward {valid, flit} and backward {on/off, allocatable}
  // travel side by side with no stalls inside the pipe.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic              in_valid;
    flit_t             in_flit;
    logic [VC_NUM-1:0] in_on;
    logic [VC_NUM-1:0] in_alloc;
    logic              valid_q;
    flit_t             flit_q;
    logic [VC_NUM-1:0] on_q;
    logic [VC_NUM-1:0] alloc_q;

    if (s == 0) begin : g_first
      assign in_valid = is_valid_i;
      assign in_flit  = data_i;
      assign in_on    = local_on;
      assign in_alloc = is_allocatable_i;
    end else begin : g_chain
      assign in_valid = g_stage[s-1].valid_q;
      assign in_flit  = g_stage[s-1].flit_q;
      assign in_on    = g_stage[s-1].on_q;
      assign in_alloc = g_stage[s-1].alloc_q;
    end

    // One stage of forward and backward retiming; reset discards flits in flight.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        flit_q  <= '0;
        on_q    <= '0;
        alloc_q <= '0;
      end else begin
        valid_q <= in_valid;
        flit_q  <= in_flit;
        on_q    <= in_on;
        alloc_q <= in_alloc;
      end
    end
  end

  assign last_valid       = g_stage[STAGES-1].valid_q;
  assign last_flit        = g_stage[STAGES-1].flit_q;
  assign is_on_off_o      = g_stage[STAGES-1].on_q;
  assign is_allocatable_o = g_stage[STAGES-1].alloc_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Per-VC skid FIFO: circular buffer, occupancy counter, sticky overflow flag.
  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    flit_t            mem [SKID_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             err_q;
    logic             hit;
    logic             full;
    logic             wr_en;
    logic             pop;

    assign hit         = last_valid && (last_flit.vc_id == VC_W'(v));
    assign full        = (occ == OCC_W'(SKID_DEPTH));
    assign wr_en       = hit && !full;
    assign pop         = grant_any && (grant_vc == RR_W'(v));
    assign nonempty[v] = (occ != '0);
    assign eligible[v] = nonempty[v] && is_on_off_i[v];
    assign local_on[v] = (occ < OCC_W'(ON_THRESH)) && is_on_off_i[v];
    assign head[v]     = mem[rd_ptr];
    assign error_o[v]  = err_q;

    // Skid storage write; contents need no reset because occ gates every read.
    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem[wr_ptr] <= last_flit;
      end
    end

    // Pointer and occupancy bookkeeping; a write into a full FIFO is dropped
    // and flagged until reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
        err_q  <= 1'b0;
      end else begin
        if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)   rd_ptr <= ptr_inc(rd_ptr);
        case ({wr_en, pop})
          2'b10:   occ <= occ + OCC_W'(1);
          2'b01:   occ <= occ - OCC_W'(1);
          default: occ <= occ;
        endcase
        if (hit && full) err_q <= 1'b1;
      end
    end
  end

  // Round-robin pick of the first eligible VC at or after rr_ptr.
  always_comb begin
    grant_any = 1'b0;
    grant_vc  = rr_ptr;
    cand      = 0;
    for (int i = 0; i < VC_NUM; i++) begin
      cand = (int'(rr_ptr) + i) % VC_NUM;
      if (!grant_any && eligible[RR_W'(cand)]) begin
        grant_any = 1'b1;
        grant_vc  = RR_W'(cand);
      end
    end
  end

  assign is_valid_o = grant_any;
  assign data_o     = head[grant_vc];

  // Advance the round-robin pointer past the granted VC; hold it when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_vc == RR_W'(VC_NUM - 1)) ? '0 : grant_vc + RR_W'(1);
    end
  end

`ifdef LINK_STATS_EN
  logic [31:0] flit_cnt_q;
  logic [31:0] stall_cnt_q;

  // Saturating counters of grants and of cycles with work queued but no grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flit_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (grant_any && (flit_cnt_q != 32'hFFFF_FFFF)) begin
        flit_cnt_q <= flit_cnt_q + 32'd1;
      end
      if ((|nonempty) && !grant_any && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign flit_cnt_o  = flit_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mesh_link_pipe.sv
// Directed testbench for mesh_link_pipe (STAGES=2, SKID_DEPTH=7, VC_NUM=4).
// Inputs change 1 ns after each rising edge. Outputs are sampled 5 ns after
// the edge, half a cycle before the next one.
module tb_mesh_link_pipe;
  import noc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  flit_t             data_i;
  logic              is_valid_i;
  logic [VC_NUM-1:0] is_on_off_o;
  logic [VC_NUM-1:0] is_allocatable_o;
  flit_t             data_o;
  logic              is_valid_o;
  logic [VC_NUM-1:0] is_on_off_i;
  logic [VC_NUM-1:0] is_allocatable_i;
  logic [VC_NUM-1:0] error_o;
`ifdef LINK_STATS_EN
  logic [31:0]       flit_cnt_o;
  logic [31:0]       stall_cnt_o;
`endif

  mesh_link_pipe #(.STAGES(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .data_i           (data_i),
    .is_valid_i       (is_valid_i),
    .is_on_off_o      (is_on_off_o),
    .is_allocatable_o (is_allocatable_o),
    .data_o           (data_o),
    .is_valid_o       (is_valid_o),
    .is_on_off_i      (is_on_off_i),
    .is_allocatable_i (is_allocatable_i),
    .error_o          (error_o)
`ifdef LINK_STATS_EN
    ,
    .flit_cnt_o       (flit_cnt_o),
    .stall_cnt_o      (stall_cnt_o)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] vc0_hold[$];
  int tests  = 0;
  int failed = 0;
  int n_sent;
  int n_off;

  function automatic flit_t mk(input int vc, input int pl);
    flit_t f;
    f.vc_id   = VC_W'(vc);
    f.payload = 30'(pl);
    return f;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    is_valid_i = 1'b0;
    data_i     = '0;
  endtask

  task automatic send(input int vc, input int pl);
    data_i     = mk(vc, pl);
    is_valid_i = 1'b1;
  endtask

  // Mid-cycle sample: every delivered flit must match the head of exp_q.
  task automatic sample();
    #4;
    if (is_valid_o !== 1'b0) begin
      if (exp_q.size() == 0) check("unexpected_valid", {31'b0, is_valid_o}, 32'd0);
      else                   check("data_o", data_o, exp_q.pop_front());
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    next();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst              = 1'b1;
    idle();
    is_on_off_i      = 4'hF;
    is_allocatable_i = 4'b1010;
    next();

    // Reset values, then on/off and allocatable appear 2 cycles after deassert.
    sample();
    check("rst_on_off", is_on_off_o, 4'h0);
    check("rst_alloc", is_allocatable_o, 4'h0);
    check("rst_error", error_o, 4'h0);
    check("rst_valid", is_valid_o, 1'b0);
    next();
    rst = 1'b0;
    sample();
    check("on_off_c0", is_on_off_o, 4'h0);
    check("alloc_c0", is_allocatable_o, 4'h0);
    next();
    sample();
    check("on_off_c1", is_on_off_o, 4'h0);
    next();
    sample();
    check("on_off_c2", is_on_off_o, 4'hF);
    check("alloc_c2", is_allocatable_o, 4'b1010);
    next();

    // 10 back-to-back VC0 flits: first out 3 cycles later, no gaps.
    for (int c = 0; c < 15; c++) begin
      if (c < 10) begin
        send(0, 'h100 + c);
        exp_q.push_back(mk(0, 'h100 + c));
      end else begin
        idle();
      end
      sample();
      check("stream_valid", is_valid_o, (c >= 3 && c < 13));
      next();
    end
    check("stream_drained", exp_q.size(), 0);
    check("stream_on_off", is_on_off_o, 4'hF);

    // VC1 streams, then downstream turns VC1 off for 20 cycles; upstream obeys.
    n_sent = 0;
    for (int c = 0; c < 4; c++) begin
      if (is_on_off_o[1]) begin
        send(1, 'h200 + n_sent);
        exp_q.push_back(mk(1, 'h200 + n_sent));
        n_sent++;
      end else begin
        idle();
      end
      step();
    end
    is_on_off_i = 4'b1101;
    n_off = 0;
    for (int c = 0; c < 20; c++) begin
      if (is_on_off_o[1]) begin
        send(1, 'h200 + n_sent);
        exp_q.push_back(mk(1, 'h200 + n_sent));
        n_sent++;
        n_off++;
      end else begin
        idle();
      end
      sample();
      check("off_valid", is_valid_o, 1'b0);
      next();
    end
    check("off_sent", n_off, 2);
    check("off_backpressure", is_on_off_o, 4'b1101);
    check("off_error", error_o, 4'h0);
    is_on_off_i = 4'hF;
    idle();
    for (int c = 0; c < 12; c++) step();
    check("off_all_delivered", exp_q.size(), 0);
    check("off_error_after", error_o, 4'h0);

    // All four VCs eligible: grants 0,1,2,3,0.
    is_on_off_i = 4'h0;
    do_reset();
    send(0, 'h300); step();
    send(1, 'h301); step();
    send(2, 'h302); step();
    send(3, 'h303); step();
    send(0, 'h310); step();
    idle();
    for (int c = 0; c < 3; c++) step();
    is_on_off_i = 4'hF;
    exp_q.push_back(mk(0, 'h300));
    exp_q.push_back(mk(1, 'h301));
    exp_q.push_back(mk(2, 'h302));
    exp_q.push_back(mk(3, 'h303));
    exp_q.push_back(mk(0, 'h310));
    for (int c = 0; c < 5; c++) begin
      sample();
      check("arb4_valid", is_valid_o, 1'b1);
      next();
    end
    step();
    check("arb4_done", exp_q.size(), 0);

    // VC2 off: grants 0,1,3,0, VC2 held until switched on.
    is_on_off_i = 4'h0;
    do_reset();
    send(0, 'h400); step();
    send(1, 'h401); step();
    send(2, 'h402); step();
    send(3, 'h403); step();
    send(0, 'h410); step();
    idle();
    for (int c = 0; c < 3; c++) step();
    is_on_off_i = 4'b1011;
    exp_q.push_back(mk(0, 'h400));
    exp_q.push_back(mk(1, 'h401));
    exp_q.push_back(mk(3, 'h403));
    exp_q.push_back(mk(0, 'h410));
    for (int c = 0; c < 4; c++) begin
      sample();
      check("arb3_valid", is_valid_o, 1'b1);
      next();
    end
    sample();
    check("arb3_vc2_held", is_valid_o, 1'b0);
    next();
    is_on_off_i = 4'hF;
    exp_q.push_back(mk(2, 'h402));
    sample();
    check("arb3_vc2_released", is_valid_o, 1'b1);
    next();
    check("arb3_done", exp_q.size(), 0);

    // Upstream ignores off and pushes SKID_DEPTH+1 flits into VC0.
    is_on_off_i = 4'b1110;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(0, 'h500 + i);
      if (i < 7) vc0_hold.push_back(mk(0, 'h500 + i));
      step();
    end
    send(1, 'h5FF);
    exp_q.push_back(mk(1, 'h5FF));
    step();
    idle();
    for (int c = 0; c < 5; c++) step();
    check("ovf_error", error_o, 4'b0001);
    check("ovf_vc1_delivered", exp_q.size(), 0);
    for (int c = 0; c < 5; c++) step();
    check("ovf_error_hold", error_o, 4'b0001);
    is_on_off_i = 4'hF;
    while (vc0_hold.size() > 0) exp_q.push_back(vc0_hold.pop_front());
    for (int c = 0; c < 10; c++) step();
    check("ovf_vc0_drained", exp_q.size(), 0);
    check("ovf_error_sticky", error_o, 4'b0001);

    // Reset pulse with 3 flits in the pipe: nothing comes out afterwards.
    do_reset();
    is_on_off_i = 4'hF;
    for (int c = 0; c < 3; c++) begin
      send(0, 'h700 + c);
      step();
    end
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      sample();
      check("post_rst_valid", is_valid_o, 1'b0);
      next();
    end
    check("post_rst_error", error_o, 4'h0);

    // 5 flits held off for 4 cycles after the first lands, then 5 grants.
    is_on_off_i = 4'h0;
    for (int c = 0; c < 5; c++) begin
      send(0, 'h600 + c);
      step();
    end
    idle();
    step();
    step();
    is_on_off_i = 4'hF;
    for (int c = 0; c < 5; c++) exp_q.push_back(mk(0, 'h600 + c));
    for (int c = 0; c < 5; c++) begin
      sample();
      check("stats_grant_valid", is_valid_o, 1'b1);
      next();
    end
    step();
    step();
`ifdef LINK_STATS_EN
    check("flit_cnt", flit_cnt_o, 32'd5);
    check("stall_cnt", stall_cnt_o, 32'd4);
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
